reg_file_param: RTL
===================

Name: reg_file_param

Overview:
- Parametrised successor of the 8-entry, 32-bit general/scratch register file used by the ALU system.
- Holds NUM_REGS registers of DATA_W bits with two combinational read ports and one multi-select write path.
- Each selected register applies a FunSel operation: inc/dec, full load, half-word load, clear.
- Adds synchronous reset, a sequential bulk-clear engine with a Busy indication, and an inc/dec wrap pulse.
- Sits between the ALU output mux and the ALU A/B operand inputs.

Parameters:
- DATA_W, 32, register width in bits; must be even and >= 4.
- NUM_REGS, 8, number of registers; must be >= 2.
- SEL_W, $clog2(NUM_REGS), width of the read-select ports; derived, not overridden.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- I  input  DATA_W  write data.
- FunSel  input  3  write operation applied to every selected register.
- RegSel  input  NUM_REGS  one-hot-or-multi write enable; bit k selects register k.
- OutASel  input  SEL_W  read index, port A.
- OutBSel  input  SEL_W  read index, port B.
- ClearAll  input  1  request to clear all registers sequentially.
- OutA  output  DATA_W  contents of register OutASel.
- OutB  output  DATA_W  contents of register OutBSel.
- Busy  output  1  bulk clear in progress.
- Wrap  output  1  registered pulse: an inc/dec wrapped last edge.

Behaviour:
- Reset (at a Clock edge with Reset=1): all registers, Busy and Wrap go to 0 and the FSM goes to IDLE. Reset overrides everything, including mid-clear.
- Reads: OutA/OutB are combinational from register contents. Latency 0 from a select change; a write is visible the cycle after its edge.
- An out-of-range select (index >= NUM_REGS) returns 0.
- Write at an edge when Busy=0 and Reset=0: every register k with RegSel[k]=1 is updated per FunSel. H = DATA_W/2.
  - 000 DEC: Q-1, modulo 2^DATA_W.
  - 001 INC: Q+1, modulo 2^DATA_W.
  - 010 LOAD: Q = I.
  - 011 CLEAR: Q = 0.
  - 100 LOAD_LO_ZX: Q = {0, I[H-1:0]}.
  - 101 LOAD_LO_KEEP: Q[H-1:0] = I[H-1:0], upper half unchanged.
  - 110 LOAD_HI_KEEP: Q[DATA_W-1:H] = I[H-1:0], lower half unchanged.
  - 111 LOAD_LO_SX: Q = sign-extended I[H-1:0].
- RegSel=0 means no change. Multiple bits set apply the same op to each register independently; INC/DEC use each register's own value.
- Wrap: set to 1 for exactly one cycle after an edge where any selected register went INC from all-ones or DEC from zero. Otherwise 0.
- FSM states: IDLE, CLEARING. Index counter idx has width SEL_W.
  - IDLE: ClearAll=1 at an edge moves to CLEARING with idx=0. A write presented at the same edge is still performed.
  - CLEARING: at each edge register[idx] is set to 0 and idx increments. At the edge where idx = NUM_REGS-1 the last register is cleared and the FSM returns to IDLE.
  - Busy = 1 exactly while in CLEARING, i.e. for NUM_REGS cycles.
  - While Busy: RegSel/FunSel writes are ignored (dropped, not queued), ClearAll is ignored, and Wrap stays 0.
  - Reads stay live during clearing: registers not yet cleared show their old values.
- Write data is sampled only at the edge. No X must be propagated from unselected registers.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined: OutA/OutB forward the value that will be written at the next edge whenever the read index is selected in RegSel and Busy=0. The forward applies the FunSel result, so same-cycle read-after-write latency is 0.
- Undefined: reads show only the stored value, as described above.
- Busy and Wrap timing are identical in both builds.

Decomposition:
- Shared package reg_file_pkg holds:
  - the FunSel encoding constants (FS_DEC … FS_LOAD_LO_SX);
  - the FSM state typedef (RF_IDLE, RF_CLEARING);
  - a function computing next-Q from (Q, I, FunSel) that returns value and wrap bit.
- Natural sub-module: reg_cell, a single DATA_W register with E, FunSel, I, a synchronous clear and Reset, plus a wrap output. It is instantiated NUM_REGS times via generate; the top holds the FSM, read muxes and bypass.

Test Plan:
- Reset, then LOAD I=0x12345678 into reg 2, read A=2 -> OutA=0x12345678 the next cycle; OutB with sel 0 reads 0.
- Reg 5 = 0xFFFFFFFF, INC -> reg 5 = 0, Wrap=1 for one cycle. Then DEC -> 0xFFFFFFFF, Wrap pulses again.
- Reg 1 = 0xAAAA5555, then LOAD_HI_KEEP with I=0x00001234 -> 0x12345555. Then LOAD_LO_SX with I=0x00008001 -> 0xFFFF8001.
- All 8 registers loaded with 0x11*k. ClearAll with a simultaneous LOAD 0xDEAD into reg 7 -> reg 7 = 0xDEAD first. Then Busy=1 for 8 cycles, regs clear in order 0..7, and a LOAD to reg 3 during Busy is dropped. All registers end at 0.
- Assert Reset at clear cycle 3 -> Busy=0 and all registers 0 next cycle. A subsequent ClearAll restarts from reg 0.
- Bypass build: LOAD 0xCAFE to reg 4 with OutASel=4 -> OutA=0xCAFE in the same cycle. Non-bypass build -> old value shown until the edge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared FunSel encodings, FSM state type and next-value function for reg_file_param.
package reg_file_pkg;

   localparam int unsigned RF_MAX_W = 128;

   localparam logic [2:0] FS_DEC          = 3'b000;
   localparam logic [2:0] FS_INC          = 3'b001;
   localparam logic [2:0] FS_LOAD         = 3'b010;
   localparam logic [2:0] FS_CLEAR        = 3'b011;
   localparam logic [2:0] FS_LOAD_LO_ZX   = 3'b100;
   localparam logic [2:0] FS_LOAD_LO_KEEP = 3'b101;
   localparam logic [2:0] FS_LOAD_HI_KEEP = 3'b110;
   localparam logic [2:0] FS_LOAD_LO_SX   = 3'b111;

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_CLEARING = 1'b1;

   typedef enum logic [0:0] {
      RF_IDLE     = ST_IDLE,
      RF_CLEARING = ST_CLEARING
   } rf_state_t;

   typedef logic [RF_MAX_W-1:0] rf_word_t;

   typedef struct packed {
      rf_word_t value;
      logic     wrap;
   } rf_next_t;

   // Operands are zero-extended to RF_MAX_W; w is the live register width.
   function automatic rf_next_t rf_next_q(input rf_word_t q, input rf_word_t din,
                                          input logic [2:0] fs, input int unsigned w);
      rf_next_t    r;
      rf_word_t    full;
      rf_word_t    lo;
      rf_word_t    qm;
      rf_word_t    dl;
      logic        sgn;
      int unsigned h;
      h    = w / 2;
      full = {RF_MAX_W{1'b1}};
      full = full >> (RF_MAX_W - w);
      lo   = {RF_MAX_W{1'b1}};
      lo   = lo >> (RF_MAX_W - h);
      qm   = q & full;
      dl   = din & lo;
      sgn  = |((din >> (h - 1)) & rf_word_t'(1));
      r.value = qm;
      r.wrap  = 1'b0;
      case (fs)
         FS_DEC: begin
            r.value = (qm - rf_word_t'(1)) & full;
            r.wrap  = (qm == '0);
         end
         FS_INC: begin
            r.value = (qm + rf_word_t'(1)) & full;
            r.wrap  = (qm == full);
         end
         FS_LOAD:         r.value = din & full;
         FS_CLEAR:        r.value = '0;
         FS_LOAD_LO_ZX:   r.value = dl;
         FS_LOAD_LO_KEEP: r.value = (qm & ~lo) | dl;
         FS_LOAD_HI_KEEP: r.value = ((dl << h) & full) | (qm & lo);
         FS_LOAD_LO_SX:   r.value = sgn ? (dl | (full & ~lo)) : dl;
         default:         r.value = qm;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// Write/read/status bundle of reg_file_param; master drives writes and selects.
interface reg_file_param_if #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 8
);
   localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [DATA_W-1:0]   I;
   logic [2:0]          FunSel;
   logic [NUM_REGS-1:0] RegSel;
   logic [SEL_W-1:0]    OutASel;
   logic [SEL_W-1:0]    OutBSel;
   logic                ClearAll;
   logic [DATA_W-1:0]   OutA;
   logic [DATA_W-1:0]   OutB;
   logic                Busy;
   logic                Wrap;

   modport master (
      output I, FunSel, RegSel, OutASel, OutBSel, ClearAll,
      input  OutA, OutB, Busy, Wrap
   );

   modport slave (
      input  I, FunSel, RegSel, OutASel, OutBSel, ClearAll,
      output OutA, OutB, Busy, Wrap
   );

endinterface

// File: rtl/reg_file_param_reg_cell.sv
// One register of the file: FunSel update on E, synchronous clear and reset, wrap flag.
module reg_cell
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              E,
   input  logic              Clr,
   input  logic [2:0]        FunSel,
   input  logic [DATA_W-1:0] I,
   output logic [DATA_W-1:0] Q,
   output logic [DATA_W-1:0] Next,
   output logic              Wrap
);

   rf_next_t nxt;
   logic     unused_hi;

   always_comb nxt = rf_next_q(rf_word_t'(Q), rf_word_t'(I), FunSel, DATA_W);

   assign Next      = nxt.value[DATA_W-1:0];
   assign Wrap      = E & nxt.wrap;
   assign unused_hi = ^nxt.value;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         Q <= '0;
      end else if (Clr) begin
         Q <= '0;
      end else if (E) begin
         Q <= Next;
      end
   end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file with FunSel writes, sequential bulk clear and wrap pulse.
// Optional same-cycle write forwarding on reads: `define REG_FILE_WRITE_BYPASS_EN.
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 8
) (
   input logic             Clock,
   input logic             Reset,
   reg_file_param_if.slave bus
);

   localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned SPAN  = 1 << SEL_W;

   rf_state_t           state;
   logic [SEL_W-1:0]    idx;
   logic                busy;
   logic                wrap_q;
   logic [NUM_REGS-1:0] cell_wrap;
   logic [DATA_W-1:0]   rd [SPAN];

   assign busy = (state == RF_CLEARING);

   // Select space is padded to a power of two; indices past NUM_REGS read as zero.
   for (genvar k = 0; k < SPAN; k++) begin : g_reg
      if (k < NUM_REGS) begin : g_cell
         logic [DATA_W-1:0] qk;
         logic [DATA_W-1:0] nk;

         reg_cell #(.DATA_W(DATA_W)) u_cell (
            .Clock  (Clock),
            .Reset  (Reset),
            .E      (bus.RegSel[k] & ~busy),
            .Clr    (busy && (idx == SEL_W'(k))),
            .FunSel (bus.FunSel),
            .I      (bus.I),
            .Q      (qk),
            .Next   (nk),
            .Wrap   (cell_wrap[k])
         );

`ifdef REG_FILE_WRITE_BYPASS_EN
         assign rd[k] = (bus.RegSel[k] && !busy) ? nk : qk;
`else
         logic unused_nk;
         assign unused_nk = ^nk;
         assign rd[k]     = qk;
`endif
      end else begin : g_pad
         assign rd[k] = '0;
      end
   end

   assign bus.OutA = rd[bus.OutASel];
   assign bus.OutB = rd[bus.OutBSel];
   assign bus.Busy = busy;
   assign bus.Wrap = wrap_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state  <= RF_IDLE;
         idx    <= '0;
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         case (state)
            RF_IDLE: begin
               wrap_q <= |cell_wrap;
               if (bus.ClearAll) begin
                  state <= RF_CLEARING;
                  idx   <= '0;
               end
            end
            RF_CLEARING: begin
               if (idx == SEL_W'(NUM_REGS - 1)) begin
                  state <= RF_IDLE;
                  idx   <= '0;
               end else begin
                  idx <= idx + SEL_W'(1);
               end
            end
            default: begin
               state <= RF_IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule
